multicycle_control: RTL and testbench

- Main control unit for the multi-cycle MIPS core.
- Sequences fetch, decode, execute, memory and writeback.
- Drives the ALUOp/operation pair consumed by the ALU control decoder.
- Handshakes with the single shared instruction/data memory port.
- Sits between the instruction register, register file, ALU control and memory interface.

---
 rtl/multicycle_control.sv | 180 ++++++++++++++++++
 tb/tb_multicycle_control.sv | 311 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/multicycle_control.sv
// rtl/multicycle_control.sv - multi-cycle MIPS main control FSM with shared memory port handshake
module multicycle_control #(
    parameter logic [5:0] OP_RTYPE = 6'b000000,
    parameter logic [5:0] OP_LDI   = 6'b001111,
    parameter logic [5:0] OP_LW    = 6'b100011,
    parameter logic [5:0] OP_SW    = 6'b101011,
    parameter logic [5:0] OP_BEQ   = 6'b000100,
    parameter logic [5:0] OP_BNE   = 6'b000101,
    parameter logic [5:0] OP_J     = 6'b000010,
    parameter logic [5:0] ADD_FUNC = 6'b100000
) (
    input  logic       clock,
    input  logic       reset,
    input  logic [5:0] opcode,
    input  logic [5:0] funct,
    input  logic       mem_ready,
    input  logic       alu_zero,
    output logic       mem_req,
    output logic       mem_we,
    output logic       iord,
    output logic       ir_write,
    output logic       pc_write,
    output logic [1:0] pc_src,
    output logic       reg_write,
    output logic       reg_dst,
    output logic       mem_to_reg,
    output logic       alu_src_b,
    output logic [2:0] ALUOp,
    output logic [5:0] operation,
    output logic [3:0] state,
    output logic       illegal
);

    typedef enum logic [3:0] {
        S_FETCH    = 4'd0,
        S_DECODE   = 4'd1,
        S_EXEC_R   = 4'd2,
        S_EXEC_LDI = 4'd3,
        S_ADDR     = 4'd4,
        S_MEM_RD   = 4'd5,
        S_MEM_WR   = 4'd6,
        S_WB_ALU   = 4'd7,
        S_WB_MEM   = 4'd8,
        S_BRANCH   = 4'd9,
        S_JUMP     = 4'd10,
        S_HALT     = 4'd11
    } state_t;

    state_t cur;
    state_t nxt;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            cur     <= S_FETCH;
            illegal <= 1'b0;
        end else begin
            cur <= nxt;
            if (cur == S_DECODE && nxt == S_HALT) begin
                illegal <= 1'b1;
            end
        end
    end

    assign state = cur;

    always_comb begin
        nxt        = cur;
        mem_req    = 1'b0;
        mem_we     = 1'b0;
        iord       = 1'b0;
        ir_write   = 1'b0;
        pc_write   = 1'b0;
        pc_src     = 2'b00;
        reg_write  = 1'b0;
        reg_dst    = 1'b0;
        mem_to_reg = 1'b0;
        alu_src_b  = 1'b0;
        ALUOp      = 3'b000;
        operation  = 6'b000000;

        case (cur)
            S_FETCH: begin
                mem_req = 1'b1;
                if (mem_ready) begin
                    ir_write = 1'b1;
                    pc_write = 1'b1;
                    nxt      = S_DECODE;
                end
            end
            S_DECODE: begin
                case (opcode)
                    OP_RTYPE:      nxt = S_EXEC_R;
                    OP_LDI:        nxt = S_EXEC_LDI;
                    OP_LW, OP_SW:  nxt = S_ADDR;
                    OP_BEQ, OP_BNE: nxt = S_BRANCH;
                    OP_J:          nxt = S_JUMP;
                    default:       nxt = S_HALT;
                endcase
            end
            S_EXEC_R: begin
                operation = funct;
                nxt       = S_WB_ALU;
            end
            S_EXEC_LDI: begin
                ALUOp     = 3'b011;
                alu_src_b = 1'b1;
                nxt       = S_WB_ALU;
            end
            S_WB_ALU: begin
                // IR is stable for the whole instruction, so opcode tells R-type from LDI here
                reg_write = 1'b1;
                if (opcode == OP_LDI) begin
                    ALUOp = 3'b011;
                end else begin
                    reg_dst   = 1'b1;
                    operation = funct;
                end
                nxt = S_FETCH;
            end
            S_ADDR: begin
                operation = ADD_FUNC;
                alu_src_b = 1'b1;
                nxt       = (opcode == OP_SW) ? S_MEM_WR : S_MEM_RD;
            end
            S_MEM_RD: begin
                mem_req = 1'b1;
                iord    = 1'b1;
                if (mem_ready) nxt = S_WB_MEM;
            end
            S_MEM_WR: begin
                mem_req = 1'b1;
                mem_we  = 1'b1;
                iord    = 1'b1;
                if (mem_ready) nxt = S_FETCH;
            end
            S_WB_MEM: begin
                reg_write  = 1'b1;
                mem_to_reg = 1'b1;
                nxt        = S_FETCH;
            end
            S_BRANCH: begin
                // ALU produces zero when the branch condition holds
                ALUOp = (opcode == OP_BNE) ? 3'b101 : 3'b100;
                if (alu_zero) begin
                    pc_write = 1'b1;
                    pc_src   = 2'b01;
                end
                nxt = S_FETCH;
            end
            S_JUMP: begin
                pc_write = 1'b1;
                pc_src   = 2'b10;
                nxt      = S_FETCH;
            end
            S_HALT: begin
                nxt = S_HALT;
            end
            default: begin
                nxt = S_FETCH;
            end
        endcase

        // Asserting reset abandons any outstanding memory request immediately
        if (reset) begin
            mem_req    = 1'b0;
            mem_we     = 1'b0;
            iord       = 1'b0;
            ir_write   = 1'b0;
            pc_write   = 1'b0;
            pc_src     = 2'b00;
            reg_write  = 1'b0;
            reg_dst    = 1'b0;
            mem_to_reg = 1'b0;
            alu_src_b  = 1'b0;
            ALUOp      = 3'b000;
            operation  = 6'b000000;
        end
    end

endmodule

// File: tb/tb_multicycle_control.sv
// tb/tb_multicycle_control.sv - randomized and directed checks of multicycle_control against a phase-list model
module tb_multicycle_control;

    localparam int S_FETCH = 0, S_DECODE = 1, S_EXEC_R = 2, S_EXEC_LDI = 3, S_ADDR = 4, S_MEM_RD = 5;
    localparam int S_MEM_WR = 6, S_WB_ALU = 7, S_WB_MEM = 8, S_BRANCH = 9, S_JUMP = 10, S_HALT = 11;
    localparam logic [5:0] OP_RTYPE = 6'b000000, OP_LDI = 6'b001111, OP_LW = 6'b100011;
    localparam logic [5:0] OP_SW = 6'b101011, OP_BEQ = 6'b000100, OP_BNE = 6'b000101, OP_J = 6'b000010;

    typedef int iq_t[$];

    logic       clock = 1'b0;
    logic       reset;
    logic [5:0] opcode, funct;
    logic       mem_ready, alu_zero;
    logic       mem_req, mem_we, iord, ir_write, pc_write, reg_write, reg_dst, mem_to_reg, alu_src_b;
    logic [1:0] pc_src;
    logic [2:0] ALUOp;
    logic [5:0] operation;
    logic [3:0] state;
    logic       illegal;

    int tests = 0;
    int fails = 0;

    int         m_state;
    bit         m_illegal;
    iq_t        m_q;
    logic [5:0] cur_op, cur_fn;
    logic [11:0] prog[$];

    always #5 clock = ~clock;

    multicycle_control dut (
        .clock(clock), .reset(reset), .opcode(opcode), .funct(funct),
        .mem_ready(mem_ready), .alu_zero(alu_zero), .mem_req(mem_req), .mem_we(mem_we),
        .iord(iord), .ir_write(ir_write), .pc_write(pc_write), .pc_src(pc_src),
        .reg_write(reg_write), .reg_dst(reg_dst), .mem_to_reg(mem_to_reg),
        .alu_src_b(alu_src_b), .ALUOp(ALUOp), .operation(operation), .state(state),
        .illegal(illegal)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Each instruction is a fixed list of phases after FETCH; only memory phases can stretch
    function automatic iq_t plan(input logic [5:0] op);
        iq_t q;
        q.push_back(S_DECODE);
        case (op)
            OP_RTYPE: begin q.push_back(S_EXEC_R); q.push_back(S_WB_ALU); end
            OP_LDI:   begin q.push_back(S_EXEC_LDI); q.push_back(S_WB_ALU); end
            OP_LW:    begin q.push_back(S_ADDR); q.push_back(S_MEM_RD); q.push_back(S_WB_MEM); end
            OP_SW:    begin q.push_back(S_ADDR); q.push_back(S_MEM_WR); end
            OP_BEQ, OP_BNE: q.push_back(S_BRANCH);
            OP_J:     q.push_back(S_JUMP);
            default:  q.push_back(S_HALT);
        endcase
        return q;
    endfunction

    function automatic logic [11:0] rand_instr();
        logic [5:0] fn;
        logic [5:0] op;
        int k;
        fn = 6'($urandom);
        k = $urandom_range(0, 15);
        if (k < 3) op = OP_RTYPE;
        else if (k < 5) op = OP_LDI;
        else if (k < 7) op = OP_LW;
        else if (k < 9) op = OP_SW;
        else if (k < 11) op = OP_BEQ;
        else if (k < 13) op = OP_BNE;
        else if (k < 15) op = OP_J;
        else op = ($urandom_range(0, 3) == 0) ? 6'($urandom) : OP_RTYPE;
        return {op, fn};
    endfunction

    task automatic compare();
        logic e_req, e_we, e_iord, e_irw, e_pcw, e_rw, e_rd, e_m2r, e_srcb;
        logic [1:0] e_pcsrc;
        logic [2:0] e_aluop;
        logic [5:0] e_op;
        e_req = 0; e_we = 0; e_iord = 0; e_irw = 0; e_pcw = 0; e_rw = 0;
        e_rd = 0; e_m2r = 0; e_srcb = 0; e_pcsrc = 0; e_aluop = 0; e_op = 0;
        case (m_state)
            S_FETCH:    begin e_req = 1; e_irw = mem_ready; e_pcw = mem_ready; end
            S_EXEC_R:   e_op = funct;
            S_EXEC_LDI: begin e_aluop = 3'd3; e_srcb = 1; end
            S_WB_ALU: begin
                e_rw = 1;
                if (opcode == OP_LDI) e_aluop = 3'd3;
                else begin e_rd = 1; e_op = funct; end
            end
            S_ADDR:     begin e_op = 6'h20; e_srcb = 1; end
            S_MEM_RD:   begin e_req = 1; e_iord = 1; end
            S_MEM_WR:   begin e_req = 1; e_iord = 1; e_we = 1; end
            S_WB_MEM:   begin e_rw = 1; e_m2r = 1; end
            S_BRANCH: begin
                e_aluop = (opcode == OP_BEQ) ? 3'd4 : 3'd5;
                e_pcw = alu_zero;
                e_pcsrc = alu_zero ? 2'd1 : 2'd0;
            end
            S_JUMP:     begin e_pcw = 1; e_pcsrc = 2'd2; end
            default: ;
        endcase
        chk("state", state, m_state);
        chk("illegal", illegal, m_illegal);
        chk("mem_req", mem_req, e_req);
        chk("mem_we", mem_we, e_we);
        chk("iord", iord, e_iord);
        chk("ir_write", ir_write, e_irw);
        chk("pc_write", pc_write, e_pcw);
        chk("pc_src", pc_src, e_pcsrc);
        chk("reg_write", reg_write, e_rw);
        chk("reg_dst", reg_dst, e_rd);
        chk("mem_to_reg", mem_to_reg, e_m2r);
        chk("alu_src_b", alu_src_b, e_srcb);
        chk("ALUOp", ALUOp, e_aluop);
        chk("operation", operation, e_op);
        chk("pcw_rw_exclusive", pc_write & reg_write, 0);
    endtask

    task automatic advance();
        logic [11:0] ins;
        bit waiting;
        waiting = (m_state == S_FETCH || m_state == S_MEM_RD || m_state == S_MEM_WR) && !mem_ready;
        if (m_state == S_HALT || waiting) return;
        if (m_state == S_FETCH) begin
            if (prog.size() > 0) ins = prog.pop_front();
            else ins = rand_instr();
            cur_op = ins[11:6];
            cur_fn = ins[5:0];
            m_q = plan(cur_op);
        end
        if (m_q.size() == 0) m_state = S_FETCH;
        else m_state = m_q.pop_front();
        if (m_state == S_HALT) m_illegal = 1;
    endtask

    task automatic run_cycle(input logic mr, input logic az);
        @(posedge clock);
        #2;
        opcode = cur_op; funct = cur_fn; mem_ready = mr; alu_zero = az;
        #4;
        compare();
        advance();
    endtask

    task automatic do_reset();
        #1 reset = 1'b1;
        #1;
        chk("rst_state", state, 0);
        chk("rst_outs", {mem_req, mem_we, iord, ir_write, pc_write, pc_src, reg_write, reg_dst,
                         mem_to_reg, alu_src_b, ALUOp, operation, illegal}, 0);
        @(posedge clock);
        #2;
        mem_ready = 1'b0;
        reset = 1'b0;
        m_state = S_FETCH;
        m_illegal = 0;
        m_q.delete();
    endtask

    task automatic test_rtype();
        int seq[5];
        int exp_seq[5];
        exp_seq = '{0, 1, 2, 7, 0};
        do_reset();
        prog.push_back({OP_RTYPE, 6'b100010});
        for (int i = 0; i < 5; i++) begin
            run_cycle(i < 4, 0);
            seq[i] = int'(state);
            if (state == 4'd2) begin
                chk("r_aluop", ALUOp, 0);
                chk("r_operation", operation, 6'b100010);
            end
            if (state == 4'd7) chk("r_wb", {reg_write, reg_dst}, 2'b11);
        end
        for (int i = 0; i < 5; i++) chk($sformatf("r_seq_%0d", i), seq[i], exp_seq[i]);
    endtask

    task automatic test_lw_wait();
        int req_cycles;
        req_cycles = 0;
        do_reset();
        prog.push_back({OP_LW, 6'h15});
        run_cycle(1, 0);
        run_cycle(1, 0);
        run_cycle(1, 0);
        chk("lw_addr_state", state, 4);
        chk("lw_addr_operation", operation, 6'b100000);
        for (int i = 0; i < 4; i++) begin
            run_cycle(i == 3, 0);
            if (mem_req && iord && state == 4'd5) req_cycles++;
        end
        chk("lw_req_cycles", req_cycles, 4);
        run_cycle(1, 0);
        chk("lw_wbmem", {state, mem_to_reg, reg_write}, {4'd8, 2'b11});
        run_cycle(0, 0);
        chk("lw_back_fetch", state, 0);
    endtask

    task automatic test_branch_jump();
        do_reset();
        prog.push_back({OP_BNE, 6'h00});
        prog.push_back({OP_BEQ, 6'h00});
        prog.push_back({OP_LDI, 6'h2a});
        prog.push_back({OP_J, 6'h00});
        run_cycle(1, 0); run_cycle(1, 0); run_cycle(1, 1);
        chk("bne_taken", {state, ALUOp, pc_write, pc_src}, {4'd9, 3'd5, 1'b1, 2'd1});
        run_cycle(1, 0);
        chk("bne_back_fetch", state, 0);
        run_cycle(1, 0); run_cycle(1, 0);
        chk("beq_not_taken", {state, ALUOp, pc_write}, {4'd9, 3'd4, 1'b0});
        run_cycle(1, 0);
        chk("beq_back_fetch", state, 0);
        run_cycle(1, 0); run_cycle(1, 0);
        chk("ldi_exec", {state, ALUOp}, {4'd3, 3'd3});
        run_cycle(1, 0);
        chk("ldi_wb", {state, reg_write, reg_dst}, {4'd7, 1'b1, 1'b0});
        run_cycle(1, 0);
        chk("j_launch_fetch", state, 0);
        run_cycle(1, 0); run_cycle(0, 0);
        chk("j_jump", {state, pc_write, pc_src}, {4'd10, 1'b1, 2'd2});
        run_cycle(0, 0);
        chk("j_three_cycles", state, 0);
    endtask

    task automatic test_latency();
        logic [5:0] ops[4];
        int lat[4];
        int n;
        ops = '{OP_SW, OP_BEQ, OP_J, OP_LDI};
        lat = '{4, 3, 3, 4};
        for (int k = 0; k < 4; k++) begin
            do_reset();
            prog.push_back({ops[k], 6'h20});
            run_cycle(1, 0);
            n = 1;
            for (int c = 0; c < 10; c++) begin
                run_cycle(1, 0);
                if (state == 4'd0) break;
                n++;
            end
            chk($sformatf("latency_%0d", k), n, lat[k]);
        end
    endtask

    task automatic test_reset_mid_read();
        do_reset();
        prog.push_back({OP_LW, 6'h00});
        run_cycle(1, 0); run_cycle(1, 0); run_cycle(1, 0); run_cycle(0, 0);
        chk("mrd_before_reset", {state, mem_req}, {4'd5, 1'b1});
        do_reset();
        run_cycle(0, 0);
        chk("mrd_after_reset", {state, mem_req, iord}, {4'd0, 1'b1, 1'b0});
    endtask

    task automatic test_halt();
        logic acc;
        acc = 0;
        do_reset();
        prog.push_back({6'b111111, 6'h00});
        run_cycle(1, 0); run_cycle(1, 0);
        for (int i = 0; i < 20; i++) begin
            run_cycle(i[0], 1'($urandom));
            acc = acc | mem_req | mem_we | ir_write | pc_write | reg_write;
        end
        chk("halt_state", state, 11);
        chk("halt_illegal", illegal, 1);
        chk("halt_strobes", acc, 0);
        do_reset();
        chk("halt_reset_clears", illegal, 0);
    endtask

    task automatic test_random();
        int halt_cnt;
        halt_cnt = 0;
        do_reset();
        for (int i = 0; i < 4000; i++) begin
            run_cycle($urandom_range(0, 3) != 0, 1'($urandom));
            if (m_state == S_HALT) halt_cnt++;
            if (halt_cnt > 3 || $urandom_range(0, 199) == 0) begin
                do_reset();
                halt_cnt = 0;
            end
        end
    endtask

    initial begin
        reset = 1'b1;
        opcode = 6'h00; funct = 6'h00; mem_ready = 1'b0; alu_zero = 1'b0;
        cur_op = 6'h00; cur_fn = 6'h00;
        m_state = S_FETCH; m_illegal = 0;
        test_rtype();
        test_lw_wait();
        test_branch_jump();
        test_latency();
        test_reset_mid_read();
        test_halt();
        test_random();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
